// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types, width codes and lane helpers for dmem_responder
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  pd;
        logic [4:0]  rob;
    } dmem_req_t;

    typedef struct packed {
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] data;
    } dmem_resp_t;

    // One load pipeline stage: raw word plus what is needed to extract it later.
    typedef struct packed {
        logic        valid;
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] word;
    } dmem_stage_t;

    // True when tag is strictly younger than ref_tag, ages measured from the ROB head.
    function automatic logic rob_younger(input logic [4:0] tag, input logic [4:0] ref_tag,
                                         input logic [4:0] head);
        logic [4:0] age_tag;
        logic [4:0] age_ref;
        age_tag = tag - head;
        age_ref = ref_tag - head;
        return age_tag > age_ref;
    endfunction

    // Byte enables of a store; SH ignores addr[0], SW ignores addr[1:0].
    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the LSB-aligned store data across every lane it may land in.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Select and extend the addressed byte/half; unknown codes return the whole word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] funct3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'b0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response/flush bundle between the memory unit and its responder
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [6:0]  req_pd;
    logic [4:0]  req_rob;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [6:0]  resp_pd;
    logic [4:0]  resp_rob;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_pd, req_rob,
        output rob_head, mispredict, mispredict_tag, resp_ready,
        input  req_ready, resp_valid, resp_pd, resp_rob, resp_data
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_pd, req_rob,
        input  rob_head, mispredict, mispredict_tag, resp_ready,
        output req_ready, resp_valid, resp_pd, resp_rob, resp_data
    );
endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - word array with byte-enable write and asynchronous read
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with pipelined loads and ROB-age flush; DMEM_PERF_EN adds perf counters
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LOAD_LAT    = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_responder_if.slave bus
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_req_t   req;
    dmem_resp_t  resp;
    dmem_stage_t st     [LOAD_LAT];
    dmem_stage_t st_nxt [LOAD_LAT];
    dmem_stage_t new_st;
    logic [LOAD_LAT-1:0] kill;
    logic        kill_new;
    logic        stall;
    logic        accept;
    logic        acc_load;
    logic        acc_store;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign req = {bus.req_is_store, bus.req_funct3, bus.req_addr, bus.req_wdata,
                  bus.req_pd, bus.req_rob};
    assign unused_addr_bits = ^req.addr[31:AW+2];

    assign stall         = st[LOAD_LAT-1].valid && !bus.resp_ready;
    assign bus.req_ready = !stall;
    assign accept        = bus.req_valid && !stall;
    assign acc_store     = accept && req.is_store;
    assign acc_load      = accept && !req.is_store;

    // A store arriving alongside reset must not reach the array.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (acc_store && !reset),
        .be    (store_be(req.funct3, req.addr[1:0])),
        .waddr (req.addr[AW+1:2]),
        .wdata (store_data(req.funct3, req.wdata)),
        .raddr (req.addr[AW+1:2]),
        .rdata (rd_word)
    );

    // Per-stage kill: entries strictly younger than the mispredicted branch.
    always_comb begin
        kill = '0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            kill[i] = bus.mispredict && rob_younger(st[i].rob, bus.mispredict_tag, bus.rob_head);
        end
    end

    assign kill_new = bus.mispredict && rob_younger(req.rob, bus.mispredict_tag, bus.rob_head);

    // Entry captured into stage 0; a younger load is accepted but enters invalid.
    always_comb begin
        new_st        = '0;
        new_st.valid  = acc_load && !kill_new;
        new_st.pd     = req.pd;
        new_st.rob    = req.rob;
        new_st.funct3 = req.funct3;
        new_st.off    = req.addr[1:0];
        new_st.word   = rd_word;
    end

    // Next pipeline state: hold (with kills) when stalled, otherwise shift by one.
    always_comb begin
        for (int i = 0; i < LOAD_LAT; i++) begin
            st_nxt[i]       = st[i];
            st_nxt[i].valid = st[i].valid && !kill[i];
        end
        if (!stall) begin
            st_nxt[0] = new_st;
            for (int i = 1; i < LOAD_LAT; i++) begin
                st_nxt[i]       = st[i-1];
                st_nxt[i].valid = st[i-1].valid && !kill[i-1];
            end
        end
    end

    // Pipeline registers; reset drops every in-flight load and zeroes the output.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (reset) begin
                st[i] <= '0;
            end else begin
                st[i] <= st_nxt[i];
            end
        end
    end

    assign resp = {st[LOAD_LAT-1].pd, st[LOAD_LAT-1].rob,
                   load_extract(st[LOAD_LAT-1].word, st[LOAD_LAT-1].funct3, st[LOAD_LAT-1].off)};

    assign bus.resp_valid = st[LOAD_LAT-1].valid;
    assign bus.resp_pd    = resp.pd;
    assign bus.resp_rob   = resp.rob;
    assign bus.resp_data  = resp.data;

`ifdef DMEM_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (acc_load && perf_loads != '1) perf_loads <= perf_loads + 32'd1;
            if (acc_store && perf_stores != '1) perf_stores <= perf_stores + 32'd1;
            if (stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

`ifdef DMEM_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

    dmem_responder #(.DEPTH_WORDS(1024), .LOAD_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_PERF_EN
        ,
        .perf_loads        (perf_loads),
        .perf_stores       (perf_stores),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [6:0] pd, input logic [4:0] rob,
                                input logic [31:0] e);
        vec_t v;
        v.is_store = s; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.pd = pd; v.rob = rob; v.exp_data = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [6:0] pd, input logic [4:0] rob);
        bus.req_valid = 1'b1; bus.req_is_store = s; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_pd = pd; bus.req_rob = rob;
    endtask

    task automatic chk_resp(input string name, input logic [6:0] pd, input logic [4:0] rob,
                            input logic [31:0] d);
        chk({name, " valid"}, {31'b0, bus.resp_valid}, 32'd1);
        chk({name, " pd"}, {25'b0, bus.resp_pd}, {25'b0, pd});
        chk({name, " rob"}, {27'b0, bus.resp_rob}, {27'b0, rob});
        chk({name, " data"}, bus.resp_data, d);
    endtask

    // One isolated request: accept, check latency, check the response (or its absence).
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.is_store, v.f3, v.addr, v.wdata, v.pd, v.rob);
        chk($sformatf("v%0d req_ready", idx), {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk($sformatf("v%0d early", idx), {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        if (v.is_store) chk($sformatf("v%0d store noresp", idx), {31'b0, bus.resp_valid}, 32'd0);
        else chk_resp($sformatf("v%0d", idx), v.pd, v.rob, v.exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_pd = '0; bus.req_rob = '0;
        bus.rob_head = '0; bus.mispredict = 1'b0; bus.mispredict_tag = '0;
        bus.resp_ready = 1'b1;

        vecs.push_back(mk(1, F3_W,  32'h40,   32'hDEADBEEF, 0,  0,  0));
        vecs.push_back(mk(0, F3_W,  32'h40,   0, 9,  3,  32'hDEADBEEF));
        vecs.push_back(mk(0, F3_B,  32'h41,   0, 10, 4,  32'hFFFFFFBE));
        vecs.push_back(mk(0, F3_BU, 32'h41,   0, 11, 5,  32'h000000BE));
        vecs.push_back(mk(0, F3_H,  32'h42,   0, 12, 6,  32'hFFFFDEAD));
        vecs.push_back(mk(0, F3_HU, 32'h42,   0, 13, 7,  32'h0000DEAD));
        vecs.push_back(mk(0, F3_B,  32'h40,   0, 14, 8,  32'hFFFFFFEF));
        vecs.push_back(mk(0, F3_BU, 32'h43,   0, 15, 9,  32'h000000DE));
        vecs.push_back(mk(0, F3_H,  32'h40,   0, 16, 10, 32'hFFFFBEEF));
        vecs.push_back(mk(0, F3_HU, 32'h41,   0, 17, 11, 32'h0000BEEF));
        vecs.push_back(mk(1, F3_B,  32'h43,   32'hFFFFFF12, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,  32'h40,   0, 18, 12, 32'h12ADBEEF));
        vecs.push_back(mk(0, F3_BU, 32'h42,   0, 19, 13, 32'h000000AD));
        vecs.push_back(mk(1, F3_W,  32'h44,   32'h0, 0, 0, 0));
        vecs.push_back(mk(1, F3_H,  32'h47,   32'hAAAA5566, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,  32'h44,   0, 20, 14, 32'h55660000));
        vecs.push_back(mk(0, F3_B,  32'h47,   0, 21, 15, 32'h00000055));
        vecs.push_back(mk(0, F3_H,  32'h46,   0, 22, 16, 32'h00005566));
        vecs.push_back(mk(1, F3_W,  32'h1048, 32'h01234567, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,  32'h48,   0, 23, 17, 32'h01234567));
        vecs.push_back(mk(0, F3_W,  32'h2048, 0, 24, 18, 32'h01234567));
        vecs.push_back(mk(0, 3'b011, 32'h40,  0, 25, 19, 32'h12ADBEEF));
        vecs.push_back(mk(0, 3'b110, 32'h41,  0, 26, 20, 32'h12ADBEEF));
        vecs.push_back(mk(1, F3_B,  32'h49,   32'h000000A5, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,  32'h48,   0, 27, 21, 32'h0123A567));
        vecs.push_back(mk(0, F3_B,  32'h49,   0, 28, 22, 32'hFFFFFFA5));

        // Reset state
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst resp_pd", {25'b0, bus.resp_pd}, 32'd0);
        chk("rst resp_rob", {27'b0, bus.resp_rob}, 32'd0);
        chk("rst resp_data", bus.resp_data, 32'd0);
        chk("rst req_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-to-back loads under a 3-cycle writeback stall
        @(negedge clk);
        bus.resp_ready = 1'b0;
        drive(0, F3_W, 32'h40, 0, 1, 1);
        chk("stall rdy0", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        drive(0, F3_W, 32'h44, 0, 2, 2);
        chk("stall rdy1", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        drive(0, F3_W, 32'h48, 0, 3, 3);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall c%0d req_ready", c), {31'b0, bus.req_ready}, 32'd0);
            chk_resp($sformatf("stall c%0d", c), 1, 1, 32'h12ADBEEF);
            if (c < 2) @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk_resp("drain l2", 2, 2, 32'h55660000);
        @(negedge clk);
        chk_resp("drain l3", 3, 3, 32'h0123A567);
        @(negedge clk);
        chk("drain empty", {31'b0, bus.resp_valid}, 32'd0);

        // Flush with head=30: tags 31 and 1 survive tag 1, tag 4 dropped at accept
        bus.rob_head = 5'd30;
        @(negedge clk);
        drive(0, F3_W, 32'h40, 0, 31, 31);
        @(negedge clk);
        drive(0, F3_W, 32'h44, 0, 32, 1);
        @(negedge clk);
        drive(0, F3_W, 32'h48, 0, 33, 4);
        bus.mispredict = 1'b1; bus.mispredict_tag = 5'd1;
        chk_resp("flush r31", 31, 31, 32'h12ADBEEF);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.mispredict = 1'b0;
        chk_resp("flush r1", 32, 1, 32'h55660000);
        @(negedge clk);
        chk("flush r4 gone a", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        chk("flush r4 gone b", {31'b0, bus.resp_valid}, 32'd0);

        // Flush during a stall kills the output stage; older entry survives
        bus.resp_ready = 1'b0;
        drive(0, F3_W, 32'h40, 0, 40, 5);
        @(negedge clk);
        drive(0, F3_W, 32'h44, 0, 41, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk_resp("sflush r5", 40, 5, 32'h12ADBEEF);
        chk("sflush stalled", {31'b0, bus.req_ready}, 32'd0);
        bus.mispredict = 1'b1; bus.mispredict_tag = 5'd2;
        @(negedge clk);
        bus.mispredict = 1'b0;
        chk("sflush r5 dropped", {31'b0, bus.resp_valid}, 32'd0);
        chk("sflush ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        chk_resp("sflush r0", 41, 0, 32'h55660000);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("sflush empty", {31'b0, bus.resp_valid}, 32'd0);
        bus.rob_head = 5'd0;

        // Reset with two loads in flight and a store in the reset cycle
        drive(0, F3_W, 32'h40, 0, 50, 6);
        @(negedge clk);
        drive(0, F3_W, 32'h44, 0, 51, 7);
        @(negedge clk);
        reset = 1'b1;
        drive(1, F3_W, 32'h40, 32'hFFFFFFFF, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        chk("mrst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("mrst req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("mrst resp_data", bus.resp_data, 32'd0);
        @(negedge clk);
        chk("mrst no late", {31'b0, bus.resp_valid}, 32'd0);
        run_vec(mk(0, F3_W, 32'h40, 0, 52, 8, 32'h12ADBEEF), 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
